mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory32 request port between three requesters: instruction fetch, data load and data store.
//  Sits between the processor core's fetch/memRead/memWrite methods and the RAM in the system model.
//  Keeps one memory transaction in flight at a time and returns each response to the requester that issued it.
//  Uses fixed priority store > load > fetch, with a starvation bound that protects fetch.
// PARAMETERS
//  XLEN          32  address/data width
//  STARVE_LIMIT  4   IDLE cycles fetch may be passed over before it is forced to win (>=1)
//  STARVE_W      3   width of the starvation counter; $clog2(STARVE_LIMIT+1)
// PORTS
//  clk              in   1     system clock, all state on rising edge
//  reset            in   1     synchronous, active-high
//  fetch_req_valid  in   1     fetch request pending
//  fetch_req_ready  out  1     fetch request accepted this cycle
//  fetch_req_addr   in   XLEN  fetch address
//  fetch_res_valid  out  1     one-cycle pulse: fetch result valid
//  fetch_res_data   out  XLEN  instruction word
//  fetch_res_exc    out  5     {valid, code[3:0]}
//  load_req_valid / load_req_ready / load_req_addr   same as fetch_req_*
//  load_res_valid / load_res_data / load_res_exc     same as fetch_res_*
//  store_req_valid  in   1     store request pending
//  store_req_ready  out  1     store request accepted this cycle
//  store_req_addr   in   XLEN  store address
//  store_req_data   in   XLEN  store data
//  store_res_valid  out  1     one-cycle pulse: store completed
//  store_res_exc    out  5     {valid, code[3:0]}
//  mem_req_valid    out  1     request to memory32
//  mem_req_ready    in   1     memory accepts the request
//  mem_req_write    out  1     1 = store, 0 = read
//  mem_req_addr     out  XLEN  memory address
//  mem_req_data     out  XLEN  store data; 0 when mem_req_write=0
//  mem_res_valid    in   1     memory response valid
//  mem_res_data     in   XLEN  read data
//  mem_res_exc      in   5     {valid, code[3:0]} from memory
// BEHAVIOUR
//  - Reset: state=IDLE, starvation counter=0. All *_ready, *_res_valid and mem_req_valid are 0. All data/exc outputs are 0.
//  - FSM states: IDLE, ISSUE, WAIT.
//  - IDLE: *_req_ready is combinational. Exactly one is high, for the winner, when any request is valid.
//    - On acceptance, the arbiter latches owner, addr, data and write. Next state is ISSUE.
//  - ISSUE: mem_req_valid=1. Its fields stay stable until mem_req_ready=1, then WAIT.
//  - WAIT: on mem_res_valid, register data/exc to the owner's outputs. The owner's *_res_valid pulses on the next cycle.
//    - Next state is IDLE.
//    - A new acceptance is allowed in that same next cycle.
//  - Minimum latency: accept at T, mem_req at T+1 (ready=1), response at T+2, *_res_valid at T+3.
//  - Priority: store > load > fetch, unless starve_cnt==STARVE_LIMIT and fetch_req_valid. In that case fetch wins.
//  - starve_cnt: +1 on each IDLE cycle where fetch_req_valid=1 and fetch loses. Saturates at STARVE_LIMIT.
//    - Cleared when fetch is accepted or fetch_req_valid=0.
//  - Misalignment (addr[1:0]!=0): the request is accepted but not issued; state stays IDLE.
//    - The owner's *_res_valid pulses at T+1 with exc={1, code} and data=0.
//    - Codes: fetch 4'd0, load 4'd4, store 4'd6.
//    - A misaligned winner still counts as a grant for starvation purposes.
//  - mem_res_exc is forwarded unchanged. read data is forwarded even when exc.valid=1.
//  - A mem_res_valid seen outside WAIT is ignored. No outputs change.
//  - Reset during ISSUE/WAIT: the transaction is abandoned, state returns to IDLE and no *_res_valid is generated. RAM shares the same reset.
// STRUCTURE
//  - Package mem_arb_pkg holds the following:
//    - typedef enum {IDLE, ISSUE, WAIT} arb_state_t
//    - typedef enum {OWN_FETCH, OWN_LOAD, OWN_STORE} arb_owner_t
//    - packed struct mem_exc_t {valid; code[3:0]}
//    - localparams EXC_INST_MISALIGN=0, EXC_LOAD_MISALIGN=4, EXC_STORE_MISALIGN=6
//  - Sub-module mem_arb_grant holds the priority logic plus the starvation counter.
//    - Inputs: 3 valids, idle. Outputs: one-hot grant.
//  - The top level holds the FSM, the request latch and response routing.
// TESTING
//  1. Reset: hold reset 2 cycles with all valids=1. All outputs read 0; first grant is store on the cycle after reset falls.
//  2. Single load 0x100, mem_req_ready=1, response 0xDEADBEEF at T+2. load_res_valid at T+3, data=0xDEADBEEF, exc=0.
//  3. Fetch, load and store valid together, continuously, STARVE_LIMIT=4. Grant order is S,S,S,S,F,... Fetch wins on the 5th grant.
//  4. Store to 0x102. store_res_valid at T+1, exc={1,6}, mem_req_valid never rises. Next request is accepted at T+1.
//  5. mem_req_ready held 0 for 3 cycles. mem_req_addr/write/data stay stable, and no new *_req_ready appears during this time.
//  6. Reset asserted in WAIT, then mem_res_valid arrives. No *_res_valid pulses, and state is IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states, owner ids
// (also used as grant bit positions) and the exception record.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} arb_owner_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } mem_exc_t;

  localparam logic [3:0] EXC_INST_MISALIGN  = 4'd0;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

  function automatic mem_exc_t misalign_exc(input arb_owner_t owner);
    mem_exc_t exc;
    exc.valid = 1'b1;
    case (owner)
      OWN_LOAD:  exc.code = EXC_LOAD_MISALIGN;
      OWN_STORE: exc.code = EXC_STORE_MISALIGN;
      default:   exc.code = EXC_INST_MISALIGN;
    endcase
    return exc;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Fixed-priority grant (store > load > fetch) with a starvation counter that
// forces fetch to win after STARVE_LIMIT lost arbitration cycles.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_valid,
  input  logic       load_valid,
  input  logic       store_valid,
  input  logic       idle,
  output logic [2:0] grant
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    if (idle) begin
      if (fetch_valid && starved) grant[OWN_FETCH] = 1'b1;
      else if (store_valid)       grant[OWN_STORE] = 1'b1;
      else if (load_valid)        grant[OWN_LOAD]  = 1'b1;
      else if (fetch_valid)       grant[OWN_FETCH] = 1'b1;
    end
  end

  // An idle cycle with fetch pending always grants someone, so "idle and not fetch" means fetch lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!fetch_valid || grant[OWN_FETCH]) begin
      starve_cnt <= '0;
    end else if (idle && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory32 request port between fetch, load and store, keeping a
// single transaction in flight and routing each response back to its issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req_valid,
  output logic            fetch_req_ready,
  input  logic [XLEN-1:0] fetch_req_addr,
  output logic            fetch_res_valid,
  output logic [XLEN-1:0] fetch_res_data,
  output logic [4:0]      fetch_res_exc,
  input  logic            load_req_valid,
  output logic            load_req_ready,
  input  logic [XLEN-1:0] load_req_addr,
  output logic            load_res_valid,
  output logic [XLEN-1:0] load_res_data,
  output logic [4:0]      load_res_exc,
  input  logic            store_req_valid,
  output logic            store_req_ready,
  input  logic [XLEN-1:0] store_req_addr,
  input  logic [XLEN-1:0] store_req_data,
  output logic            store_res_valid,
  output logic [4:0]      store_res_exc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_write,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  input  logic            mem_res_valid,
  input  logic [XLEN-1:0] mem_res_data,
  input  logic [4:0]      mem_res_exc
);

  arb_state_t      state, state_nxt;
  arb_owner_t      owner_q, win_owner;
  logic [XLEN-1:0] addr_q, data_q, win_addr;
  logic            write_q;
  logic            idle, accept, win_misaligned;
  logic [2:0]      grant;

  logic [2:0]           res_valid_q;
  mem_exc_t [2:0]       res_exc_q;
  logic [XLEN-1:0]      fetch_data_q, load_data_q;

  // Readies must stay low while reset is held, even though the state already reads IDLE.
  assign idle = (state == IDLE) && !reset;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_grant (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_req_valid),
    .load_valid  (load_req_valid),
    .store_valid (store_req_valid),
    .idle        (idle),
    .grant       (grant)
  );

  assign accept = |grant;

  always_comb begin
    win_owner = OWN_FETCH;
    win_addr  = fetch_req_addr;
    if (grant[OWN_STORE]) begin
      win_owner = OWN_STORE;
      win_addr  = store_req_addr;
    end else if (grant[OWN_LOAD]) begin
      win_owner = OWN_LOAD;
      win_addr  = load_req_addr;
    end
  end

  assign win_misaligned = (win_addr[1:0] != 2'b00);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !win_misaligned) state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready)              state_nxt = WAIT;
      WAIT:    if (mem_res_valid)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch_req_ready = grant[OWN_FETCH];
    load_req_ready  = grant[OWN_LOAD];
    store_req_ready = grant[OWN_STORE];
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    if (state == ISSUE && !reset) begin
      mem_req_valid = 1'b1;
      mem_req_write = write_q;
      mem_req_addr  = addr_q;
      mem_req_data  = data_q;
    end
  end

  // Read data is latched as zero so the issued request carries data=0 for reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_FETCH;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else if (accept && !win_misaligned) begin
      owner_q <= win_owner;
      addr_q  <= win_addr;
      write_q <= (win_owner == OWN_STORE);
      data_q  <= (win_owner == OWN_STORE) ? store_req_data : '0;
    end
  end

  // Misaligned requests complete locally; aligned ones complete on the WAIT-state response.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q  <= '0;
      res_exc_q    <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
    end else begin
      res_valid_q <= '0;
      if (accept && win_misaligned) begin
        res_valid_q[win_owner] <= 1'b1;
        res_exc_q[win_owner]   <= misalign_exc(win_owner);
        if (win_owner == OWN_FETCH) fetch_data_q <= '0;
        if (win_owner == OWN_LOAD)  load_data_q  <= '0;
      end else if (state == WAIT && mem_res_valid) begin
        res_valid_q[owner_q] <= 1'b1;
        res_exc_q[owner_q]   <= mem_res_exc;
        if (owner_q == OWN_FETCH) fetch_data_q <= mem_res_data;
        if (owner_q == OWN_LOAD)  load_data_q  <= mem_res_data;
      end
    end
  end

  assign fetch_res_valid = res_valid_q[OWN_FETCH];
  assign load_res_valid  = res_valid_q[OWN_LOAD];
  assign store_res_valid = res_valid_q[OWN_STORE];
  assign fetch_res_exc   = res_exc_q[OWN_FETCH];
  assign load_res_exc    = res_exc_q[OWN_LOAD];
  assign store_res_exc   = res_exc_q[OWN_STORE];
  assign fetch_res_data  = fetch_data_q;
  assign load_res_data   = load_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic fetch_req_valid, fetch_req_ready, fetch_res_valid;
  logic load_req_valid, load_req_ready, load_res_valid;
  logic store_req_valid, store_req_ready, store_res_valid;
  logic [XLEN-1:0] fetch_req_addr, fetch_res_data, load_req_addr, load_res_data;
  logic [XLEN-1:0] store_req_addr, store_req_data;
  logic [4:0] fetch_res_exc, load_res_exc, store_res_exc, mem_res_exc;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_res_valid;
  logic [XLEN-1:0] mem_req_addr, mem_req_data, mem_res_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .STARVE_W(3)) dut (
    .clk(clk), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_addr(fetch_req_addr), .fetch_res_valid(fetch_res_valid),
    .fetch_res_data(fetch_res_data), .fetch_res_exc(fetch_res_exc),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .load_req_addr(load_req_addr), .load_res_valid(load_res_valid),
    .load_res_data(load_res_data), .load_res_exc(load_res_exc),
    .store_req_valid(store_req_valid), .store_req_ready(store_req_ready),
    .store_req_addr(store_req_addr), .store_req_data(store_req_data),
    .store_res_valid(store_res_valid), .store_res_exc(store_res_exc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_res_valid(mem_res_valid),
    .mem_res_data(mem_res_data), .mem_res_exc(mem_res_exc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] readies();
    return {store_req_ready, load_req_ready, fetch_req_ready};
  endfunction

  function automatic logic [2:0] pulses();
    return {store_res_valid, load_res_valid, fetch_res_valid};
  endfunction

  function automatic logic [4:0] exc_of(input logic [2:0] oh);
    case (oh)
      3'b001:  return fetch_res_exc;
      3'b010:  return load_res_exc;
      default: return store_res_exc;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [2:0] oh);
    return (oh == 3'b001) ? fetch_res_data : load_res_data;
  endfunction

  function automatic logic [4:0] misalign_code(input int idx);
    case (idx)
      0:       return {1'b1, EXC_INST_MISALIGN};
      1:       return {1'b1, EXC_LOAD_MISALIGN};
      default: return {1'b1, EXC_STORE_MISALIGN};
    endcase
  endfunction

  task automatic idle_inputs();
    fetch_req_valid = 1'b0; load_req_valid = 1'b0; store_req_valid = 1'b0;
    fetch_req_addr = '0; load_req_addr = '0; store_req_addr = '0; store_req_data = '0;
    mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_res_data = '0; mem_res_exc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        fv, lv, sv;
    logic [31:0] addr;
    logic [31:0] mem_data;
    logic [4:0]  mem_exc;
    logic [2:0]  exp_ready;
    logic [4:0]  exp_exc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] sdata;
    sdata = 32'hA5A5_0000 | v.addr;
    @(negedge clk);
    fetch_req_valid = v.fv; load_req_valid = v.lv; store_req_valid = v.sv;
    fetch_req_addr = v.addr; load_req_addr = v.addr; store_req_addr = v.addr;
    store_req_data = sdata;
    #1 check($sformatf("vec%0d ready", idx), readies(), v.exp_ready);
    @(negedge clk);
    fetch_req_valid = 1'b0; load_req_valid = 1'b0; store_req_valid = 1'b0;
    #1;
    if (v.addr[1:0] != 2'b00) begin
      check($sformatf("vec%0d misalign pulse", idx), pulses(), v.exp_ready);
      check($sformatf("vec%0d misalign exc", idx), exc_of(v.exp_ready), v.exp_exc);
      if (v.exp_ready != 3'b100) check($sformatf("vec%0d misalign data", idx), data_of(v.exp_ready), v.exp_data);
      check($sformatf("vec%0d no mem req", idx), mem_req_valid, 0);
    end else begin
      check($sformatf("vec%0d mem_req_valid", idx), mem_req_valid, 1);
      check($sformatf("vec%0d mem_req_addr", idx), mem_req_addr, v.addr);
      check($sformatf("vec%0d mem_req_write", idx), mem_req_write, v.exp_ready[2]);
      check($sformatf("vec%0d mem_req_data", idx), mem_req_data, v.exp_ready[2] ? sdata : 32'h0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; mem_res_valid = 1'b1; mem_res_data = v.mem_data; mem_res_exc = v.mem_exc;
      #1 check($sformatf("vec%0d req dropped", idx), mem_req_valid, 0);
      check($sformatf("vec%0d no early pulse", idx), pulses(), 0);
      @(negedge clk);
      mem_res_valid = 1'b0;
      #1 check($sformatf("vec%0d pulse T+3", idx), pulses(), v.exp_ready);
      check($sformatf("vec%0d res exc", idx), exc_of(v.exp_ready), v.exp_exc);
      if (v.exp_ready != 3'b100) check($sformatf("vec%0d res data", idx), data_of(v.exp_ready), v.exp_data);
    end
    @(negedge clk);
    #1 check($sformatf("vec%0d single pulse", idx), pulses(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] starve_exp[6];
    int got;
    bit resp_pend;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'h00, 3'b010, 5'h00, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h13579BDF, 5'h00, 3'b001, 5'h00, 32'h13579BDF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h300, 32'h0,        5'h15, 3'b100, 5'h15, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h040, 32'h11112222, 5'h00, 3'b100, 5'h00, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h044, 32'hCAFEF00D, 5'h00, 3'b010, 5'h00, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h201, 32'h0,        5'h00, 3'b001, 5'h10, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h103, 32'h0,        5'h00, 3'b010, 5'h14, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h102, 32'h0,        5'h00, 3'b010, 5'h14, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h12345678, 5'h1B, 3'b010, 5'h1B, 32'h12345678};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 32'h306, 32'h0,        5'h00, 3'b100, 5'h16, 32'h0};

    // Reset held with every request valid: all outputs quiet, store wins first.
    idle_inputs();
    reset = 1'b1;
    fetch_req_valid = 1'b1; load_req_valid = 1'b1; store_req_valid = 1'b1;
    fetch_req_addr = 32'h10; load_req_addr = 32'h20; store_req_addr = 32'h30; store_req_data = 32'h55;
    repeat (2) @(negedge clk);
    #1 check("reset readies", readies(), 0);
    check("reset pulses", pulses(), 0);
    check("reset mem_req_valid", mem_req_valid, 0);
    check("reset mem_req_fields", {mem_req_write, mem_req_addr, mem_req_data}, 0);
    check("reset res data", {fetch_res_data, load_res_data}, 0);
    check("reset res exc", {fetch_res_exc, load_res_exc, store_res_exc}, 0);
    reset = 1'b0;
    #1 check("first grant after reset", readies(), 3'b100);

    do_reset();
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Starvation: all three valid back to back; fetch must win the fifth grant.
    do_reset();
    starve_exp = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
    @(negedge clk);
    fetch_req_valid = 1'b1; load_req_valid = 1'b1; store_req_valid = 1'b1;
    fetch_req_addr = 32'h1000; load_req_addr = 32'h2000; store_req_addr = 32'h3000;
    store_req_data = 32'h77; mem_req_ready = 1'b1;
    got = 0; resp_pend = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      mem_res_valid = resp_pend;
      mem_res_data = 32'(cyc);
      #1;
      resp_pend = mem_req_valid;
      if (readies() != 3'b000) begin
        check($sformatf("starve grant %0d", got), readies(), starve_exp[got]);
        got++;
      end
      @(negedge clk);
    end
    check("starve grants seen", got, 6);

    // Misaligned store completes at T+1 and the next request is accepted in that cycle.
    do_reset();
    @(negedge clk);
    store_req_valid = 1'b1; store_req_addr = 32'h102; store_req_data = 32'h99;
    #1 check("misalign store ready", readies(), 3'b100);
    @(negedge clk);
    store_req_valid = 1'b0; load_req_valid = 1'b1; load_req_addr = 32'h100;
    #1 check("misalign store pulse", pulses(), 3'b100);
    check("misalign store exc", store_res_exc, 5'h16);
    check("misalign store no mem req", mem_req_valid, 0);
    check("accept at T+1", readies(), 3'b010);
    @(negedge clk);
    load_req_valid = 1'b0;
    #1 check("follow-on load issued", {mem_req_valid, mem_req_addr}, {1'b1, 32'h100});

    // Stall: memory not ready for 3 cycles with other requesters waiting.
    do_reset();
    @(negedge clk);
    load_req_valid = 1'b1; load_req_addr = 32'h104;
    @(negedge clk);
    load_req_valid = 1'b0; fetch_req_valid = 1'b1; store_req_valid = 1'b1;
    fetch_req_addr = 32'h400; store_req_addr = 32'h500; store_req_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("stall%0d mem_req", i), {mem_req_valid, mem_req_write, mem_req_addr, mem_req_data},
               {1'b1, 1'b0, 32'h104, 32'h0});
      check($sformatf("stall%0d no ready", i), readies(), 0);
      @(negedge clk);
    end

    // Reset during WAIT abandons the transaction; a late response is ignored.
    do_reset();
    @(negedge clk);
    load_req_valid = 1'b1; load_req_addr = 32'h108;
    @(negedge clk);
    load_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_res_valid = 1'b1; mem_res_data = 32'hBAD0BAD0;
    #1 check("abandon no pulse a", pulses(), 0);
    check("abandon no mem req", mem_req_valid, 0);
    @(negedge clk);
    mem_res_valid = 1'b0;
    #1 check("abandon no pulse b", pulses(), 0);
    fetch_req_valid = 1'b1; fetch_req_addr = 32'h0;
    #1 check("abandon back in idle", readies(), 3'b001);

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    begin
      bit pend[3];
      logic [31:0] paddr[3];
      logic [31:0] pdata;
      bit busy, issued, fv;
      int own, win, cnt;
      logic [31:0] m_addr, m_data;
      bit m_wr;
      logic [2:0] exp_ready, exp_pulse, nxt_pulse;
      logic [4:0] exp_exc, nxt_exc;
      logic [31:0] exp_data, nxt_data;
      pend = '{0, 0, 0}; paddr = '{0, 0, 0}; pdata = '0;
      busy = 0; issued = 0; own = 0; cnt = 0; m_addr = '0; m_data = '0; m_wr = 0;
      exp_pulse = '0; exp_exc = '0; exp_data = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int i = 0; i < 3; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1;
            paddr[i] = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) paddr[i] = paddr[i] | 32'($urandom_range(1, 3));
            if (i == 2) pdata = $urandom;
          end else if (pend[i] && $urandom_range(0, 15) == 0) begin
            pend[i] = 0;
          end
        end
        fetch_req_valid = pend[0]; load_req_valid = pend[1]; store_req_valid = pend[2];
        fetch_req_addr = paddr[0]; load_req_addr = paddr[1]; store_req_addr = paddr[2];
        store_req_data = pdata;
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_res_valid = (busy && issued) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        mem_res_data = $urandom;
        mem_res_exc = 5'($urandom);

        fv = pend[0];
        win = -1;
        if (!busy) begin
          if (pend[0] && cnt == LIMIT) win = 0;
          else if (pend[2])            win = 2;
          else if (pend[1])            win = 1;
          else if (pend[0])            win = 0;
        end
        exp_ready = (win >= 0) ? 3'(1 << win) : 3'b000;

        #1;
        check($sformatf("rand%0d ready", cyc), readies(), exp_ready);
        check($sformatf("rand%0d mem_req_valid", cyc), mem_req_valid, busy && !issued);
        if (busy && !issued)
          check($sformatf("rand%0d mem_req", cyc), {mem_req_write, mem_req_addr, mem_req_data},
                {m_wr, m_addr, m_data});
        check($sformatf("rand%0d pulses", cyc), pulses(), exp_pulse);
        if (exp_pulse != 3'b000) begin
          check($sformatf("rand%0d exc", cyc), exc_of(exp_pulse), exp_exc);
          if (exp_pulse != 3'b100) check($sformatf("rand%0d data", cyc), data_of(exp_pulse), exp_data);
        end

        nxt_pulse = '0; nxt_exc = '0; nxt_data = '0;
        if (win >= 0) begin
          if (paddr[win][1:0] != 2'b00) begin
            nxt_pulse = exp_ready;
            nxt_exc = misalign_code(win);
          end else begin
            busy = 1; issued = 0; own = win;
            m_addr = paddr[win]; m_wr = (win == 2); m_data = (win == 2) ? pdata : 32'h0;
          end
          pend[win] = 0;
        end else if (busy && !issued && mem_req_ready) begin
          issued = 1;
        end else if (busy && issued && mem_res_valid) begin
          nxt_pulse = 3'(1 << own);
          nxt_exc = mem_res_exc;
          nxt_data = mem_res_data;
          busy = 0;
        end
        if (!fv || win == 0)           cnt = 0;
        else if (win > 0 && cnt < LIMIT) cnt++;
        exp_pulse = nxt_pulse; exp_exc = nxt_exc; exp_data = nxt_data;
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
